// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg
//
// Parametrised pipeline register: DEPTH stages of WIDTH bits, each with its
// own valid bit, joined by a valid/ready handshake at both ends. A valid stage
// moves forward whenever the stage ahead of it is empty or is itself moving,
// so bubbles collapse even while the output is stalled. Words leave in strict
// FIFO order, and none are dropped or duplicated.
//
// Parameters:
//   WIDTH     data width in bits (>= 1)
//   DEPTH     number of register stages (>= 1)
//   RESET_VAL value loaded into every data stage on reset
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all valid bits (only with PIPE_REG_FLUSH_EN)
//   in_valid   upstream word available
//   in_ready   stage 0 can accept this cycle (combinational from out_ready)
//   in_data    upstream word
//   out_valid  last stage holds a valid word
//   out_ready  downstream accepts this cycle
//   out_data   last-stage data
//   occupancy  registered count of valid stages (0..DEPTH)
//
// Optional feature macro: PIPE_REG_FLUSH_EN adds the flush input. While flush
// is high, in_ready and out_valid are forced low, no data register moves, and
// every valid bit and the occupancy count clear at the next edge.
// -----------------------------------------------------------------------------
module pipe_reg #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef PIPE_REG_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_r;
    logic [DEPTH-1:0] v_nxt_s;
    logic [DEPTH-1:0] adv_s;
    logic [DEPTH:0]   v_ext_s;
    logic             carry_s;
    logic [WIDTH-1:0] d_r     [DEPTH];
    logic [WIDTH-1:0] d_nxt_s [DEPTH];
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;
    logic             flush_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             emit_s;

`ifdef PIPE_REG_FLUSH_EN
    assign flush_s = flush;
`else
    assign flush_s = 1'b0;
`endif

    // Advance chain, walked from the output back to stage 0. A constant-1
    // sentinel above the last stage turns the generic term into
    // v[DEPTH-1] & out_ready for the last stage. Flush blocks every move so
    // the data registers stay untouched.
    always_comb begin
        v_ext_s = {1'b1, v_r};
        carry_s = out_ready;
        adv_s   = {DEPTH{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv_s[k] = v_ext_s[k] & (~v_ext_s[k+1] | carry_s) & ~flush_s;
            carry_s  = adv_s[k];
        end
    end

    // Handshake at both ends of the chain.
    always_comb begin
        in_ready_s = (~v_r[0] | adv_s[0]) & ~flush_s;
        accept_s   = in_valid & in_ready_s;
        emit_s     = adv_s[DEPTH-1];
    end

    // Next state of the stage valid bits and data registers. A stage that
    // empties keeps its stale data, because only its valid bit drops.
    always_comb begin
        v_nxt_s = v_r & ~adv_s;
        d_nxt_s = d_r;
        if (accept_s) begin
            v_nxt_s[0] = 1'b1;
            d_nxt_s[0] = in_data;
        end else begin
            v_nxt_s[0] = v_nxt_s[0];
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (adv_s[k-1]) begin
                v_nxt_s[k] = 1'b1;
                d_nxt_s[k] = d_r[k-1];
            end else begin
                v_nxt_s[k] = v_nxt_s[k];
            end
        end
        if (flush_s) begin
            v_nxt_s = {DEPTH{1'b0}};
        end else begin
            v_nxt_s = v_nxt_s;
        end
    end

    // Next occupancy: +1 on accept, -1 on emit, unchanged on both or neither.
    always_comb begin
        occ_nxt_s = occ_r;
        if (flush_s) begin
            occ_nxt_s = {OCC_W{1'b0}};
        end else begin
            case ({accept_s, emit_s})
                2'b10:   occ_nxt_s = occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
                2'b01:   occ_nxt_s = occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
                default: occ_nxt_s = occ_r;
            endcase
        end
    end

    // Stage and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r   <= {DEPTH{1'b0}};
            occ_r <= {OCC_W{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                d_r[k] <= RESET_VAL;
            end
        end else begin
            v_r   <= v_nxt_s;
            occ_r <= occ_nxt_s;
            d_r   <= d_nxt_s;
        end
    end

    // Output drive; valid and data come straight from the last stage register.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = v_r[DEPTH-1] & ~flush_s;
        out_data  = d_r[DEPTH-1];
        occupancy = occ_r;
    end

endmodule

// File: tb/tb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_reg
//
// Directed, self-checking bench for pipe_reg with WIDTH=8, DEPTH=4 and
// RESET_VAL=0. It covers reset, single-word latency, backpressure, full-pipe
// streaming, asynchronous reset mid-stream and, when PIPE_REG_FLUSH_EN is
// defined, flush. Inputs change 1 time unit after each rising edge, and the
// outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_pipe_reg;

    logic       clk;
    logic       rst_n;
`ifdef PIPE_REG_FLUSH_EN
    logic       flush;
`endif
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] occupancy;

    int total;
    int passed;
    int fails;

    pipe_reg #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef PIPE_REG_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        fails  = 0;
`ifdef PIPE_REG_FLUSH_EN
        flush  = 1'b0;
`endif
        // Reset with a word offered: nothing may be accepted.
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'h00);
        chk("rst_occupancy", {29'd0, occupancy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        chk("post_rst_occupancy", {29'd0, occupancy}, 32'd0);

        // Latency: one word into an empty pipe.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        #1;
        chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("lat_occ_after_push", {29'd0, occupancy}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_data", {24'd0, out_data}, 32'hA5);
        tick();
        chk("lat_pop_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_pop_occ", {29'd0, occupancy}, 32'd0);

        // Backpressure: four words fill the pipe, the fifth is refused.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i);
            #1;
            chk("bp_fill_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_data = 8'h05;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_full_occ", {29'd0, occupancy}, 32'd4);
            chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_stall_data", {24'd0, out_data}, 32'h01);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            in_valid = (j <= 2);
            in_data  = 8'(j + 4);
            #1;
            chk("bp_drain_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_drain_data", {24'd0, out_data}, 32'(j));
            tick();
        end
        chk("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_empty_occ", {29'd0, occupancy}, 32'd0);

        // Full-pipe streaming: one in and one out per cycle.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h10 + i);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = 8'(8'h14 + c);
            #1;
            chk("st_in_ready", {31'd0, in_ready}, 32'd1);
            chk("st_out_valid", {31'd0, out_valid}, 32'd1);
            chk("st_out_data", {24'd0, out_data}, 32'(8'h10 + c));
            chk("st_occ", {29'd0, occupancy}, 32'd4);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("st_tail_data", {24'd0, out_data}, 32'(8'h1A + c));
            tick();
        end
        chk("st_done_occ", {29'd0, occupancy}, 32'd0);

        // Asynchronous reset with three words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h31 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("ar_pre_occ", {29'd0, occupancy}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_occ", {29'd0, occupancy}, 32'd0);
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_data", {24'd0, out_data}, 32'h00);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("ar_no_old_word", {31'd0, out_valid}, 32'd0);
            tick();
        end
        chk("ar_new_valid", {31'd0, out_valid}, 32'd1);
        chk("ar_new_data", {24'd0, out_data}, 32'h77);
        tick();
        chk("ar_new_gone", {31'd0, out_valid}, 32'd0);
        chk("ar_final_occ", {29'd0, occupancy}, 32'd0);

`ifdef PIPE_REG_FLUSH_EN
        // Flush with three words in flight and a word offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h41 + i);
            tick();
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h44;
        #1;
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_occ", {29'd0, occupancy}, 32'd0);
        chk("fl_after_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("fl_push_valid", {31'd0, out_valid}, 32'd1);
        chk("fl_push_data", {24'd0, out_data}, 32'h55);
        tick();
        chk("fl_push_occ", {29'd0, occupancy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
# pipe_reg

Parametrised pipeline register: a chain of DEPTH clocked stages, each WIDTH bits wide, with a valid/ready handshake at both ends. Empty stages collapse, so bubbles disappear when the output is stalled. It is the general-purpose replacement for single D flip-flops wherever the design needs to retime a data path or add latency. It also absorbs backpressure without losing or duplicating data.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- RESET_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream word available
- in_ready  output  1  stage 0 can accept this cycle
- in_data  input  WIDTH  upstream word
- out_valid  output  1  last stage holds a valid word
- out_ready  input  1  downstream accepts this cycle
- out_data  output  WIDTH  last-stage data
- occupancy  output  $clog2(DEPTH+1)  number of valid stages
- flush  input  1  synchronous pipeline clear; present only with PIPE_REG_FLUSH_EN

One clock; reset is asynchronous and active-low.

## Operation
- State:
  - per stage k (0..DEPTH-1): valid bit v[k] and data register d[k]
  - stage DEPTH-1 drives out_valid and out_data
- Advance rule:
  - adv[DEPTH-1] = v[DEPTH-1] & out_ready
  - adv[k] = v[k] & (~v[k+1] | adv[k+1])
  - an advancing stage copies its data into stage k+1
  - stage 0 loads in_data when in_valid & in_ready
- in_ready = ~v[0] | adv[0]. This is a combinational ready chain from out_ready; no registered ready.
- Stall behaviour:
  - a stage that neither advances nor empties holds d[k] and v[k] unchanged
  - out_data is stable while out_valid=1 and out_ready=0
- Bubble collapse: a valid stage advances into an empty stage ahead of it even when the output is stalled.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- occupancy:
  - registered count of set v[k]
  - +1 on accept, −1 on output transfer, unchanged on both or neither
  - range 0..DEPTH
- Invalid data: d[k] is not cleared when its stage empties. out_data is meaningful only when out_valid=1.

## Timing
- Reset (rst_n low, asynchronous assert):
  - all v[k]=0, all d[k]=RESET_VAL
  - out_valid=0, out_data=RESET_VAL, occupancy=0
  - in_ready=1 combinationally during reset
- Reset release is synchronous to clk; the first accept can occur on the first rising edge after rst_n rises.
- Latency: a word accepted at edge N into an empty pipe shows out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Full pipe:
  - all v=1 with out_ready=0 gives in_ready=0
  - all v=1 with out_ready=1 gives in_ready=1: accept and emit in the same cycle, occupancy stays DEPTH
- Empty pipe: out_valid=0; out_ready is ignored.
- Reset mid-stream: all in-flight words are discarded immediately and no partial transfer completes.
- DEPTH=1: degenerates to a single handshake register with combinational pass-through of ready.

## Configuration
- PIPE_REG_FLUSH_EN defined:
  - adds the flush input
  - while flush=1: in_ready=0 and out_valid=0, forced combinationally, so no transfers occur
  - at the next edge all v[k]=0 and occupancy=0
  - data registers are untouched
  - flush has priority over every transfer in the same cycle
- Not defined: no flush port and no flush logic; the pipe is cleared only by rst_n.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 and in_data=0xFF → out_valid=0, out_data=RESET_VAL (0x00), occupancy=0, no word accepted.
- Latency (DEPTH=4): push 0xA5 into an empty pipe with out_ready=1 → out_valid=1 with out_data=0xA5 exactly 4 cycles after the push; occupancy returns to 0 after the pop.
- Backpressure: out_ready=0, offer 0x01..0x06 → 0x01..0x04 accepted, in_ready=0, occupancy=4; then out_ready=1 → 0x01..0x04 emitted back-to-back, then 0x05 and 0x06, with no gaps and no loss.
- Full-pipe streaming: pipe full and in_valid=out_ready=1 for 10 cycles → one word in and one word out per cycle, occupancy constant at 4, order preserved.
- Async reset mid-stream: drop rst_n between clock edges with 3 words in flight → outputs go to reset values immediately; after release the pipe is empty and the next push emits only the new word.
- Flush (PIPE_REG_FLUSH_EN): 3 words in flight, pulse flush for one cycle while in_valid=1 → no word accepted or emitted that cycle, occupancy=0 next cycle, and subsequent pushes flow normally.
